// File: rtl/trig_frame_tx.sv
// Trigger event framer: numbers each accepted trigger, queues it in a small FIFO
// and serializes queued events as start/data/odd-parity/stop frames on ser_out.
module trig_frame_tx #(
  parameter int BIT_DIV   = 4,
  parameter int GUARD_CYC = 4,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     ene,
  input  logic                     trigger,
  output logic                     ser_out,
  output logic                     busy,
  output logic [15:0]              evt_count,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

  state_t          state;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [18:0]     shreg;
  logic [4:0]      bit_cnt;
  logic [DW-1:0]   div_cnt;
  logic [GW-1:0]   grd_cnt;

  logic            acc, full, push, pop;
  logic [15:0]     evt_base, drop_base, head;

  assign acc       = trigger & ene;
  // full uses the registered occupancy, so a push racing a pop on a full FIFO drops
  assign full      = (fifo_level == (AW+1)'(DEPTH));
  assign push      = acc & ~full;
  assign pop       = (state == IDLE) && (fifo_level != '0);
  assign evt_base  = clr ? 16'd0 : evt_count;
  assign drop_base = clr ? 16'd0 : drop_count;
  assign head      = mem[rptr];
  assign busy      = (fifo_level != '0) || (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_count  <= '0;
      drop_count <= '0;
    end else begin
      evt_count <= evt_base + {15'd0, acc};
      if (acc && full)
        drop_count <= (drop_base == 16'hFFFF) ? 16'hFFFF : drop_base + 16'd1;
      else
        drop_count <= drop_base;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= evt_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ser_out <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      grd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          ser_out <= 1'b0;
          if (pop) begin
            shreg   <= {1'b1, head, ~^head, 1'b0};
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          ser_out <= shreg[18];
          if (div_cnt == DW'(BIT_DIV - 1)) begin
            div_cnt <= '0;
            shreg   <= {shreg[17:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd18) begin
              grd_cnt <= '0;
              state   <= (GUARD_CYC == 0) ? IDLE : GUARD;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GUARD: begin
          ser_out <= 1'b0;
          if (grd_cnt == GW'(GUARD_CYC - 1)) state <= IDLE;
          else grd_cnt <= grd_cnt + 1'b1;
        end
        default: begin
          ser_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_frame_tx.sv
// Directed bench for trig_frame_tx: a line monitor decodes frames, checks go through one task.
module tb_trig_frame_tx;
  localparam int BIT_DIV = 4, GUARD_CYC = 4, DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, ene = 1'b0, trigger = 1'b0;
  logic ser_out, busy;
  logic [15:0] evt_count, drop_count;
  logic [$clog2(DEPTH):0] fifo_level;

  trig_frame_tx #(.BIT_DIV(BIT_DIV), .GUARD_CYC(GUARD_CYC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ene(ene), .trigger(trigger),
    .ser_out(ser_out), .busy(busy), .evt_count(evt_count),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int hi_cnt = 0;
  always @(negedge clk) if (!rst && ser_out) hi_cnt <= hi_cnt + 1;

  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // frame decoder: sample the first cycle of every bit, discard frames cut by reset
  logic [18:0] frm_q[$];
  int          st_q[$];
  initial begin : mon
    logic [18:0] w;
    logic        bad;
    int          st;
    forever begin
      @(negedge clk);
      if (!rst && ser_out) begin
        w = '0; w[18] = 1'b1; st = cyc; bad = 1'b0;
        for (int i = 1; i < 19; i++) begin
          repeat (BIT_DIV) begin
            @(negedge clk);
            if (rst) bad = 1'b1;
          end
          w[18-i] = ser_out;
        end
        if (!bad) begin
          frm_q.push_back(w);
          st_q.push_back(st);
        end
      end
    end
  end

  int rd = 0;

  task automatic chk_frame(input string tag, input logic [18:0] exp);
    if (frm_q.size() > rd) begin
      check(tag, frm_q[rd], exp);
      rd++;
    end else begin
      check({tag, "_cnt"}, frm_q.size(), rd + 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; ene = 1'b1; trigger = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd = frm_q.size();
  endtask

  // trigger high for n consecutive rising edges; returns at the negedge after the last one
  task automatic trig(input int n);
    @(negedge clk);
    trigger = 1'b1;
    repeat (n) @(negedge clk);
    trigger = 1'b0;
  endtask

  int h0, n0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ser", ser_out, 0);
    check("rst_busy", busy, 0);
    check("rst_evt", evt_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_lvl", fifo_level, 0);
    rst = 1'b0; ene = 1'b1;

    // single trigger: latency, start bit width, busy drop, frame content
    trig(1);
    check("t1_lvl", fifo_level, 1);
    check("t1_evt", evt_count, 1);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_lvl_pop", fifo_level, 0);
    check("t1_ser_pre", ser_out, 0);
    @(negedge clk);
    check("t1_ser_rise", ser_out, 1);
    repeat (3) @(negedge clk);
    check("t1_ser_hold", ser_out, 1);
    @(negedge clk);
    check("t1_ser_msb", ser_out, 0);
    repeat (74) @(negedge clk);
    check("t1_busy80", busy, 1);
    @(negedge clk);
    check("t1_busy81", busy, 0);
    chk_frame("t1_frame", 19'h40002);

    // three consecutive triggers
    do_reset();
    trig(3);
    check("t2_lvl", fifo_level, 2);
    check("t2_evt", evt_count, 3);
    repeat (250) @(negedge clk);
    chk_frame("t2_f0", 19'h40002);
    chk_frame("t2_f1", 19'h40004);
    if (rd >= 2) check("t2_gap1", st_q[rd-1] - st_q[rd-2], 81);
    chk_frame("t2_f2", 19'h40008);
    if (rd >= 2) check("t2_gap2", st_q[rd-1] - st_q[rd-2], 81);

    // overflow: 10 back-to-back triggers
    do_reset();
    trig(10);
    check("t3_evt", evt_count, 10);
    check("t3_drop", drop_count, 5);
    check("t3_lvl", fifo_level, 4);
    repeat (420) @(negedge clk);
    chk_frame("t3_f0", 19'h40002);
    chk_frame("t3_f1", 19'h40004);
    chk_frame("t3_f2", 19'h40008);
    chk_frame("t3_f3", 19'h4000E);
    chk_frame("t3_f4", 19'h40010);
    check("t3_nomore", frm_q.size(), rd);
    check("t3_busy", busy, 0);

    // ene gating and clr
    do_reset();
    ene = 1'b0;
    trig(3);
    check("t4_off_evt", evt_count, 0);
    check("t4_off_lvl", fifo_level, 0);
    ene = 1'b1;
    trig(6);
    check("t4_evt6", evt_count, 6);
    check("t4_drop1", drop_count, 1);
    ene = 1'b0;
    trig(3);
    check("t4_off2_evt", evt_count, 6);
    check("t4_off2_drop", drop_count, 1);
    ene = 1'b1;
    @(negedge clk); clr = 1'b1; trigger = 1'b1;
    @(negedge clk); clr = 1'b0; trigger = 1'b0;
    check("t4_clrfull_evt", evt_count, 1);
    check("t4_clrfull_drop", drop_count, 1);
    repeat (450) @(negedge clk);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("t4_clr_evt", evt_count, 0);
    check("t4_clr_drop", drop_count, 0);
    @(negedge clk); clr = 1'b1; trigger = 1'b1;
    @(negedge clk); clr = 1'b0; trigger = 1'b0;
    check("t4_clrtrg_evt", evt_count, 1);
    check("t4_clrtrg_drop", drop_count, 0);
    repeat (90) @(negedge clk);
    chk_frame("t4_f0", 19'h40002);
    chk_frame("t4_f1", 19'h40004);
    chk_frame("t4_f2", 19'h40008);
    chk_frame("t4_f3", 19'h4000E);
    chk_frame("t4_f4", 19'h40010);
    chk_frame("t4_fclr", 19'h40002);

    // reset in the middle of frame 0x00A5 with two events queued
    do_reset();
    trig(165);
    check("t5_evt", evt_count, 16'h00A5);
    repeat (480) @(negedge clk);
    check("t5_idle", busy, 0);
    rd = frm_q.size();
    trig(3);
    repeat (33) @(negedge clk);
    check("t5_lvl", fifo_level, 2);
    rst = 1'b1;
    #1;
    check("t5_ser", ser_out, 0);
    check("t5_busy", busy, 0);
    check("t5_evt0", evt_count, 0);
    check("t5_drop0", drop_count, 0);
    check("t5_lvl0", fifo_level, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    h0 = hi_cnt;
    n0 = frm_q.size();
    repeat (300) @(negedge clk);
    check("t5_quiet", hi_cnt, h0);
    check("t5_noframe", frm_q.size(), n0);

    // event number wrap and drop saturation
    do_reset();
    trig(65535);
    check("t6_evt", evt_count, 16'hFFFF);
    check("t6_drop", drop_count, 16'hFCD1);
    repeat (500) @(negedge clk);
    check("t6_idle", busy, 0);
    rd = frm_q.size();
    trig(2);
    check("t6_wrap", evt_count, 1);
    repeat (200) @(negedge clk);
    chk_frame("t6_fffff", 19'h7FFFE);
    chk_frame("t6_f0000", 19'h40002);
    trig(1000);
    check("t6_sat", drop_count, 16'hFFFF);
    check("t6_evt2", evt_count, 16'd1001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trig_frame_tx.md
# trig_frame_tx

Downstream consumer of the trigger-pulse generator. Each single-cycle trigger pulse is assigned a 16-bit event number and queued in a small FIFO. Queued events are serialized as framed, parity-protected words on a one-wire line toward the front-end modules. Event and drop counters are exposed for status readout.

## Interface
- BIT_DIV, 4: clock cycles per serial bit (≥1)
- GUARD_CYC, 4: idle cycles forced after each frame's stop bit (≥0)
- DEPTH, 4: event FIFO depth (power of 2, ≥2)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of evt_count and drop_count
- ene  in  1  trigger accept enable
- trigger  in  1  trigger pulse; every high cycle is one trigger
- ser_out  out  1  serial frame line, idle low
- busy  out  1  high when FIFO is non-empty or the FSM is not IDLE
- evt_count  out  16  triggers accepted, including dropped ones; wraps
- drop_count  out  16  triggers lost to a full FIFO; saturates at 0xFFFF
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Reset: ser_out=0, busy=0, evt_count=0, drop_count=0, fifo_level=0, FSM=IDLE, FIFO emptied. Reset mid-frame aborts the frame immediately; no partial resumption.
- Trigger accept: when trigger=1 and ene=1 in a cycle:
  - The event number is the current evt_count value, and evt_count increments.
  - If the FIFO is not full, the number is written.
  - If the FIFO is full, drop_count increments and nothing is written.
  - The full test uses the registered occupancy before that cycle's pop, so a push while full with a simultaneous pop is still dropped.
- ene=0: triggers are ignored and not counted. Queued events and an in-flight frame complete normally.
- clr=1: evt_count and drop_count become 0. A trigger in the same cycle gets number 0, and evt_count ends at 1. If that trigger is dropped, drop_count ends at 1. The FIFO and FSM are unaffected.
- Frame: 19 bits, in order:
  - start bit 1
  - event number bits [15:0], MSB first
  - odd parity bit (data + parity contain an odd number of ones)
  - stop bit 0
- Each frame bit is held for BIT_DIV cycles.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head, load the shift register, go to SHIFT.
  - SHIFT: drive the bits. After the stop bit's last cycle, go to GUARD, or go straight to IDLE if GUARD_CYC=0.
  - GUARD: ser_out=0 for GUARD_CYC cycles, then IDLE.
- ser_out is a register output with no combinational path from inputs.

## Timing
- Push/pop latency:
  - A trigger sampled at edge E into an empty FIFO with FSM in IDLE shows fifo_level=1 after E.
  - The pop and load occur at E+1, and ser_out rises after E+2.
- Frame duration: 19·BIT_DIV cycles. Back-to-back frames are separated by GUARD_CYC guard cycles plus 1 IDLE pop cycle. With defaults: 76 + 4 + 1 = 81 cycles per event.
- fifo_level changes by at most ±1 per cycle. A simultaneous push and pop leaves it unchanged.
- busy drops the cycle after the FSM enters IDLE with an empty FIFO.
- Counter updates are visible the cycle after the trigger edge.

## Test plan
- Single trigger after reset, defaults, ene=1 → frame 1,0x0000,1,0. ser_out high for 4 cycles starting 2 edges after the trigger. busy low 81 cycles after the trigger. evt_count=1.
- Triggers on 3 consecutive cycles → three frames carrying 0x0000, 0x0001, 0x0002 with parities 1, 0, 0. Frame starts are 81 cycles apart. fifo_level peaks at 2.
- 10 back-to-back triggers, DEPTH=4 → first event in flight, 4 queued, 5 dropped. evt_count=10, drop_count=5. Numbers 0–4 are transmitted; 5–9 are never sent.
- Triggers with ene=0, then clr together with a trigger, ene=1 → ignored triggers leave the counters unchanged. After clr: evt_count=1, the frame carries 0x0000, drop_count=0.
- Assert rst mid-frame (bit 8 of event 0x00A5), with 2 events queued → ser_out=0 immediately. All counters and fifo_level are 0, and no further frames are sent after release.
- Preload evt_count to 0xFFFF via 65535 triggers → next event number is 0xFFFF (parity 1), the following one is 0x0000. drop_count driven past 0xFFFF stays at 0xFFFF.
